// File: rtl/rmii_rx_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rmii_rx_frame_gen                                            |
// | Description : Cycle-accurate RMII receive-side frame source. On a start    |
// |               pulse it emits lead-in, preamble, SFD, payload (LSB dibit    |
// |               first), optional FCS and an inter-packet gap on crsdv/rxd.   |
// | Config      : define RMII_FCS_EN to append a CRC-32 FCS after the payload. |
// | Ports       : clk, rstn (sync, active-low)                                 |
// |               start, len        - frame request and payload byte count     |
// |               data, data_vld    - payload byte stream in                   |
// |               data_rdy          - byte consumed this cycle when data_vld=1 |
// |               crsdv, rxd        - RMII receive outputs (registered)        |
// |               busy, done        - frame in progress / completion pulse     |
// |               underrun          - pulse when a required byte was missing   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rmii_rx_frame_gen #(
  parameter int PREAMBLE_DIBITS = 31,
  parameter int IPG_CYCLES      = 96,
  parameter int LEN_W           = 11
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       data,
  input  logic             data_vld,
  output logic             data_rdy,
  output logic             crsdv,
  output logic [1:0]       rxd,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int FCS_DIBITS = 16;
  localparam int CNT_MAX_A  = (PREAMBLE_DIBITS > IPG_CYCLES) ? PREAMBLE_DIBITS : IPG_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_A > FCS_DIBITS) ? CNT_MAX_A : FCS_DIBITS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
`ifdef RMII_FCS_EN
  localparam int SH_W = 32;  // also carries the 4 FCS bytes
`else
  localparam int SH_W = 8;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_PRE  = 3'd2,
    S_SFD  = 3'd3,
    S_DATA = 3'd4,
    S_FCS  = 3'd5,
    S_IPG  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;   // preamble / FCS / IPG cycle counter
  logic [LEN_W-1:0] rem_q, rem_d;   // bytes not yet fully transmitted
  logic [1:0]       dib_q, dib_d;   // dibit index within current byte
  logic [SH_W-1:0]  sh_q, sh_d;     // output shift register, low dibit on the wire
  logic             crsdv_q, crsdv_d;
  logic [1:0]       rxd_q, rxd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic             tail_d;         // payload finished (or empty) this cycle
`ifdef RMII_FCS_EN
  logic [31:0]      crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  // Fetch points: the SFD cycle for the first byte, then the last dibit of
  // each byte while another byte is still owed.
  assign data_rdy = ((state_q == S_SFD)  && (rem_q != '0)) ||
                    ((state_q == S_DATA) && (dib_q == 2'd3) && (rem_q > LEN_W'(1)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dib_d      = dib_q;
    sh_d       = sh_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    tail_d     = 1'b0;
`ifdef RMII_FCS_EN
    crc_d      = crc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEAD;
          rem_d   = len;
          cnt_d   = '0;
          dib_d   = '0;
`ifdef RMII_FCS_EN
          crc_d   = '1;
`endif
        end
      end
      S_LEAD: begin
        state_d = S_PRE;
        cnt_d   = '0;
      end
      S_PRE: begin
        if (cnt_q == CNT_W'(PREAMBLE_DIBITS - 1)) begin
          state_d = S_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SFD: begin
        if (rem_q == '0) begin
          tail_d = 1'b1;
        end else begin
          state_d = S_DATA;
          dib_d   = '0;
        end
      end
      S_DATA: begin
        dib_d = dib_q + 2'd1;
        sh_d  = sh_q >> 2;
        if (dib_q == 2'd3) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) tail_d = 1'b1;
        end
      end
      S_FCS: begin
        sh_d = sh_q >> 2;
        if (cnt_q == CNT_W'(FCS_DIBITS - 1)) begin
          state_d = S_IPG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IPG: begin
        // cnt 0..IPG_CYCLES-1 are the gap; cnt==IPG_CYCLES is the done cycle,
        // which keeps start blocked until the following cycle.
        if (cnt_q == CNT_W'(IPG_CYCLES)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          done_d = (cnt_q == CNT_W'(IPG_CYCLES - 1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (data_rdy) begin
      if (data_vld) begin
        sh_d  = SH_W'(data);
`ifdef RMII_FCS_EN
        crc_d = crc_byte(crc_q, data);
`endif
      end else begin
        // Missing byte: abandon the payload, skip FCS, go straight to the gap.
        underrun_d = 1'b1;
        state_d    = S_IPG;
        cnt_d      = '0;
      end
    end

    if (tail_d) begin
`ifdef RMII_FCS_EN
      state_d = S_FCS;
      sh_d    = ~crc_q;
`else
      state_d = S_IPG;
`endif
      cnt_d = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    crsdv_d = (state_d == S_LEAD) || (state_d == S_PRE) || (state_d == S_SFD) ||
              (state_d == S_DATA) || (state_d == S_FCS);
    unique case (state_d)
      S_PRE:         rxd_d = 2'b01;
      S_SFD:         rxd_d = 2'b11;
      S_DATA, S_FCS: rxd_d = sh_d[1:0];
      default:       rxd_d = 2'b00;
    endcase
    busy_d = (state_d != S_IDLE) && !done_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dib_q      <= '0;
      sh_q       <= '0;
      crsdv_q    <= 1'b0;
      rxd_q      <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef RMII_FCS_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dib_q      <= dib_d;
      sh_q       <= sh_d;
      crsdv_q    <= crsdv_d;
      rxd_q      <= rxd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
`ifdef RMII_FCS_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign crsdv    = crsdv_q;
  assign rxd      = rxd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule
`default_nettype wire
